// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe
// Description : Segmented, valid/ready pipelined adder/subtractor with carry,
//               signed-overflow and zero flags. Define ADDSUB_PIPE_SAT_EN to
//               saturate the result on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_NSEG = WIDTH / SEG_WIDTH;

    // Per-stage inputs: index k is what stage k consumes this cycle.
    logic [WIDTH-1:0] w_a_in   [c_NSEG];
    logic [WIDTH-1:0] w_b_in   [c_NSEG];
    logic [WIDTH-1:0] w_res_in [c_NSEG];
    logic             w_c_in   [c_NSEG];
    logic             w_v_in   [c_NSEG];

    logic             w_adv;
    logic             r_ovalid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    assign w_adv     = !r_ovalid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_ovalid;
    assign out       = r_out;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

    // Subtraction is A + ~B + 1: invert once at entry, carry-in supplies the +1.
    assign w_a_in[0]   = in1;
    assign w_b_in[0]   = op_sub ? ~in2 : in2;
    assign w_res_in[0] = '0;
    assign w_c_in[0]   = op_sub;
    assign w_v_in[0]   = in_valid;

    for (genvar k = 0; k < c_NSEG; k++) begin : g_stage
        logic [SEG_WIDTH:0] w_seg;

        assign w_seg = {1'b0, w_a_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                     + {1'b0, w_b_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                     + (SEG_WIDTH+1)'(w_c_in[k]);

        if (k < c_NSEG - 1) begin : g_mid
            logic [WIDTH-1:0] w_res_next;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_res;
            logic             r_c;
            logic             r_v;

            always_comb begin
                w_res_next = w_res_in[k];
                w_res_next[k*SEG_WIDTH +: SEG_WIDTH] = w_seg[SEG_WIDTH-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (w_adv) begin
                    r_v <= w_v_in[k];
                end
                if (w_adv) begin
                    r_a   <= w_a_in[k];
                    r_b   <= w_b_in[k];
                    r_res <= w_res_next;
                    r_c   <= w_seg[SEG_WIDTH];
                end
            end

            assign w_a_in[k+1]   = r_a;
            assign w_b_in[k+1]   = r_b;
            assign w_res_in[k+1] = r_res;
            assign w_c_in[k+1]   = r_c;
            assign w_v_in[k+1]   = r_v;
        end else begin : g_last
            logic [WIDTH-1:0] w_sum;
            logic [WIDTH-1:0] w_res_out;
            logic             w_a_msb;
            logic             w_b_msb;
            logic             w_ovf;
            logic             w_unused;

            always_comb begin
                w_sum = w_res_in[k];
                w_sum[k*SEG_WIDTH +: SEG_WIDTH] = w_seg[SEG_WIDTH-1:0];
            end

            assign w_a_msb  = w_a_in[k][WIDTH-1];
            assign w_b_msb  = w_b_in[k][WIDTH-1];
            assign w_ovf    = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
            // Lower operand segments are already consumed by this point.
            assign w_unused = ^{w_a_in[k], w_b_in[k]};

`ifdef ADDSUB_PIPE_SAT_EN
            localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
            assign w_res_out = !w_ovf ? w_sum : (w_a_msb ? c_SAT_MIN : c_SAT_MAX);
`else
            assign w_res_out = w_sum;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovalid <= 1'b0;
                    r_out    <= '0;
                    r_carry  <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_zero   <= 1'b0;
                end else if (w_adv) begin
                    r_ovalid <= w_v_in[k];
                    r_out    <= w_res_out;
                    r_carry  <= w_seg[SEG_WIDTH];
                    r_ovf    <= w_ovf;
                    r_zero   <= (w_res_out == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// Bench for addsub_pipe (WIDTH=32, SEG_WIDTH=8): directed vectors with
// literal expectations plus a queue-based arithmetic model checked every cycle.
module tb_addsub_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    wire          in_ready;
    wire          out_valid;
    wire  [W-1:0] out;
    wire          carry_out;
    wire          overflow;
    wire          zero;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(32), .SEG_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } res_t;

    res_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] bp;
        logic [63:0]  us;
        longint       sa, sb, ss;
        res_t         e;
        bp  = sub ? ~b : b;
        us  = {32'd0, a} + {32'd0, bp} + {63'd0, sub};
        sa  = longint'($signed(a));
        sb  = longint'($signed(bp));
        ss  = sa + sb + longint'(sub);
        e.c = us[32];
        e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
`ifdef ADDSUB_PIPE_SAT_EN
        if (ss > 64'sd2147483647)       e.r = 32'h7FFF_FFFF;
        else if (ss < -64'sd2147483648) e.r = 32'h8000_0000;
        else                            e.r = us[31:0];
`else
        e.r = us[31:0];
`endif
        return e;
    endfunction

    // Compare process: acts on what the next rising edge will do.
    logic        stall_prev = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {out, carry_out, overflow, zero}, held);
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("model_out",      out,       e.r);
                    chk("model_carry",    carry_out, e.c);
                    chk("model_overflow", overflow,  e.v);
                    chk("model_zero",     zero,      e.r == '0);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out, carry_out, overflow, zero};
            if (in_valid && in_ready)
                q.push_back(model(in1, in2, op_sub));
        end
    end

    task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] eo, input logic ec,
                            input logic ev, input logic ez);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        op_sub    = sub;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"},  lat,       3);
        chk({nm, "_out"},      out,       eo);
        chk({nm, "_carry"},    carry_out, ec);
        chk({nm, "_overflow"}, overflow,  ev);
        chk({nm, "_zero"},     zero,      ez);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, guard;
        logic acc;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out",       out,       '0);
        chk("reset_flags",     {carry_out, overflow, zero}, 3'b000);
        chk("reset_in_ready",  in_ready,  1'b1);

        directed("wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_PIPE_SAT_EN
        directed("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        directed("neg_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        directed("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("neg_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        directed("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_nobrw",  32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        directed("sub_zero",   32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Streaming with pseudo-random back-pressure.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in1       = $urandom;
        in2       = $urandom;
        op_sub    = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        cnt = 0;
        guard = 0;
        while (cnt < 16 && guard < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                cnt++;
                if (cnt < 16) begin
                    in1    = $urandom;
                    in2    = $urandom;
                    op_sub = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("stream_accepted", cnt, 16);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("stream_drained", q.size(), 0);

        // Reset with three beats in flight; an accept is offered during reset.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in1    = 32'd100 + 32'(i);
            in2    = 32'd1;
            op_sub = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_out",       out,       '0);
        chk("rst_mid_in_ready",  in_ready,  1'b1);
        directed("rst_fresh", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
